// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, opcode encodings and the result-slot state type
// used by the ALU, instruction decode and the issue arbiter.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int CTRL_W = 3;
    localparam int CNT_W  = 8;

    localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [CTRL_W-1:0] ALU_XOR = 3'b100;
    localparam logic [CTRL_W-1:0] ALU_SHL = 3'b101;
    localparam logic [CTRL_W-1:0] ALU_INC = 3'b110;
    localparam logic [CTRL_W-1:0] ALU_PASS = 3'b111;

    // Result slot occupancy; EMPTY means rsp_valid is low.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/alu_issue_arbiter_rr_arb2.sv
// Two-way round-robin grant logic; purely combinational, one-hot output.
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: gnt gets a default before any branch so no path leaves it unassigned and no latch is inferred.
        gnt = 2'b00;
        if (en) begin
            // On contention the requester that did not win last time goes first.
            if (valid0 && valid1) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = {valid1, valid0};
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin issue, a one-entry
// result register tagged with the requester ID, and saturating per-requester grant counters.
module alu_issue_arbiter #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int CTRL_W = alu_pkg::CTRL_W,
    parameter int CNT_W  = alu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_cout,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_cout,
    output logic              rsp_id,

    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);

    import alu_pkg::*;

    rsp_state_t state_q;
    rsp_state_t state_d;
    logic       rr_last;
    logic       slot_free;
    logic       grant_en;
    logic       grant;
    logic       win_id;
    logic [1:0] gnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A full slot can still take a new result in the cycle the consumer drains it.
    assign slot_free = (state_q == RSP_EMPTY) || rsp_ready;
    assign grant_en  = slot_free && !rst;

    rr_arb2 u_rr_arb2 (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .last   (rr_last),
        .en     (grant_en),
        .gnt    (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign grant      = |gnt;
    assign win_id     = gnt[1];
    assign rsp_valid  = (state_q == RSP_FULL);

    // Zeros when idle keep the ALU inputs defined and quiet.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        unique case (gnt)
            2'b01: begin
                alu_a    = req0_a;
                alu_b    = req0_b;
                alu_ctrl = req0_ctrl;
            end
            2'b10: begin
                alu_a    = req1_a;
                alu_b    = req1_b;
                alu_ctrl = req1_ctrl;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (grant) begin
            state_d = RSP_FULL;
        end else if ((state_q == RSP_FULL) && rsp_ready) begin
            state_d = RSP_EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RSP_EMPTY;
            rr_last  <= 1'b1;
            // NOTE: the result payload is a few flops, so it is reset explicitly; a wide storage array would not be.
            rsp_data <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= 1'b0;
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                rsp_data <= alu_out;
                rsp_cout <= alu_cout;
                rsp_id   <= win_id;
                rr_last  <= win_id;
            end
            if (gnt[0]) begin
                gnt_cnt0 <= sat_inc(gnt_cnt0);
            end
            if (gnt[1]) begin
                gnt_cnt1 <= sat_inc(gnt_cnt1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_alu_issue_arbiter;

    localparam int DW = 8;
    localparam int CW = 3;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [CW-1:0] req0_ctrl, req1_ctrl;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [CW-1:0] alu_ctrl;
    logic          alu_cout;
    logic          rsp_valid, rsp_ready, rsp_cout, rsp_id;
    logic [DW-1:0] rsp_data;
    logic [NW-1:0] gnt_cnt0, gnt_cnt1;

    always #5 clk = ~clk;

    // ALU stub: plain 8-bit add with carry out.
    always_comb {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};

    alu_issue_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the consumer should see, plus round-robin history.
    bit m_full;
    int m_data, m_cout, m_id, m_last, m_cnt0, m_cnt1;
    int last_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_data = 0;
        m_cout = 0;
        m_id   = 0;
        m_last = 1;
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    // One clock: check everything at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        int w;
        int sum;
        logic [31:0] exp_a, exp_b, exp_c;
        @(negedge clk);
        w = -1;
        if (!rst && (!m_full || rsp_ready)) begin
            if (req0_valid && req1_valid) w = (m_last == 1) ? 0 : 1;
            else if (req0_valid)          w = 0;
            else if (req1_valid)          w = 1;
        end
        exp_a = (w == 0) ? 32'(req0_a)    : (w == 1) ? 32'(req1_a)    : 32'd0;
        exp_b = (w == 0) ? 32'(req0_b)    : (w == 1) ? 32'(req1_b)    : 32'd0;
        exp_c = (w == 0) ? 32'(req0_ctrl) : (w == 1) ? 32'(req1_ctrl) : 32'd0;
        check("req0_ready", 32'(req0_ready), 32'(w == 0));
        check("req1_ready", 32'(req1_ready), 32'(w == 1));
        check("alu_a", 32'(alu_a), exp_a);
        check("alu_b", 32'(alu_b), exp_b);
        check("alu_ctrl", 32'(alu_ctrl), exp_c);
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        check("rsp_data", 32'(rsp_data), 32'(m_data));
        check("rsp_cout", 32'(rsp_cout), 32'(m_cout));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt0));
        check("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt1));
        last_w = w;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (w >= 0) begin
            sum    = (w == 0) ? int'(req0_a) + int'(req0_b) : int'(req1_a) + int'(req1_b);
            m_data = sum % 256;
            m_cout = sum / 256;
            m_id   = w;
            m_last = w;
            m_full = 1'b1;
            if (w == 0) m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
            else        m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Requesters only change valid/payload once the previous op was accepted (or none was pending).
    task automatic rand_req(input int pct);
        if (!req0_valid || last_w == 0) begin
            req0_valid = ($urandom_range(99) < pct);
            req0_a     = DW'($urandom);
            req0_b     = DW'($urandom);
            req0_ctrl  = CW'($urandom);
        end
        if (!req1_valid || last_w == 1) begin
            req1_valid = ($urandom_range(99) < pct);
            req1_a     = DW'($urandom);
            req1_b     = DW'($urandom);
            req1_ctrl  = CW'($urandom);
        end
    endtask

    initial begin
        int held;
        last_w     = -1;
        rst        = 1'b1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd5; req0_ctrl = 3'b110;
        req1_valid = 1'b0; req1_a = '0;   req1_b = '0;   req1_ctrl = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with a pending request.
        cycle();
        cycle();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_cnt0", 32'(gnt_cnt0), 32'd0);
        rst = 1'b0;

        // Single op, granted the same cycle.
        cycle();
        req0_valid = 1'b0;
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_data", 32'(rsp_data), 32'd14);
        check("single_cout", 32'(rsp_cout), 32'd0);
        check("single_id", 32'(rsp_id), 32'd0);

        // Carry out from requester 1.
        req1_valid = 1'b1; req1_a = 8'd200; req1_b = 8'd100; req1_ctrl = 3'b000;
        cycle();
        req1_valid = 1'b0;
        check("carry_data", 32'(rsp_data), 32'd44);
        check("carry_cout", 32'(rsp_cout), 32'd1);
        check("carry_id", 32'(rsp_id), 32'd1);
        check("carry_cnt1", 32'(gnt_cnt1), 32'd1);

        // Contention from a fresh reset: strict alternation starting with req0.
        reset_pulse();
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2;
        req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd4;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("cont_id", 32'(rsp_id), 32'(i % 2));
        end
        check("cont_cnt0", 32'(gnt_cnt0), 32'd2);
        check("cont_cnt1", 32'(gnt_cnt1), 32'd2);

        // Backpressure: slot full, nothing granted, result frozen.
        rsp_ready = 1'b0;
        held = m_data;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_ready0", 32'(req0_ready), 32'd0);
            check("bp_hold", 32'(rsp_data), 32'(held));
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_drain_valid", 32'(rsp_valid), 32'd1);
        check("bp_drain_id", 32'(rsp_id), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle();

        // Counter saturation, then reset while a result is pending.
        reset_pulse();
        req0_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            req0_a = DW'($urandom);
            req0_b = DW'($urandom);
            cycle();
        end
        check("sat_cnt0", 32'(gnt_cnt0), 32'd255);
        check("sat_full", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_full_valid", 32'(rsp_valid), 32'd0);
        check("rst_full_cnt0", 32'(gnt_cnt0), 32'd0);
        req0_valid = 1'b0;
        cycle();

        // Randomized traffic with random backpressure and occasional reset.
        last_w = -1;
        for (int i = 0; i < 3000; i++) begin
            rand_req(60);
            rsp_ready = ($urandom_range(99) < 70);
            rst       = ($urandom_range(199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
